count_snapshot_tx: RTL and testbench
====================================

Name: count_snapshot_tx

Overview:
- Downstream consumer of the dual 64-bit counter block (Output0/Output1).
- On a snapshot request, captures both counts atomically in one cycle, then streams them out as a byte-wide framed packet over a valid/ready handshake.
- Sits between the counter and a UART or debug byte sink. The counter keeps running while a frame drains.

Parameters:
- CNT_W, 64, width of each counter input; must be a multiple of 8.
- HDR_BYTE, 8'hA5, constant first byte of every frame.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset (Reset==0 resets).
- Cnt0  input  CNT_W  live count from counter Output0.
- Cnt1  input  CNT_W  live count from counter Output1.
- Snap  input  1  single-cycle snapshot request.
- Busy  output  1  frame in progress (registered).
- Snap_Miss  output  1  sticky: a Snap arrived while busy and was dropped.
- Tx_Data  output  8  frame byte.
- Tx_Valid  output  1  Tx_Data valid.
- Tx_Ready  input  1  sink accepts byte when Tx_Valid && Tx_Ready at a rising edge.
- Tx_Last  output  1  qualifies the final byte of the frame.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - State=IDLE; snapshot registers, byte index and checksum cleared.
  - Busy, Snap_Miss, Tx_Valid, Tx_Last = 0; Tx_Data = 0.
  - A partially sent frame is abandoned; no resumption.
- States: IDLE, HDR, C0, C1, CKS.
- IDLE:
  - On Snap=1, latch Cnt0/Cnt1 at that edge; next state HDR.
  - Busy=1 and Tx_Valid=1 from the next cycle. Latency Snap -> first valid byte = 1 cycle.
- HDR: Tx_Data=HDR_BYTE; on handshake go to C0 with index=0.
- C0: Tx_Data = snap0 byte[index], LSB byte first. On handshake, index++. After byte CNT_W/8-1, go to C1 with index=0.
- C1: same as C0 for snap1. After its final byte, go to CKS.
- CKS: Tx_Data = XOR of all 2*CNT_W/8 payload bytes (header excluded); Tx_Last=1. On handshake, the frame ends.
- Handshake rules:
  - While Tx_Valid && !Tx_Ready, Tx_Data and Tx_Last are held stable.
  - Tx_Valid never drops mid-frame.
- Frame length is 2+2*CNT_W/8 bytes (18 at default).
- Checksum is accumulated from the latched snapshot, never from live inputs.
- Snap while Busy (not final-byte handshake cycle): dropped, Snap_Miss set to 1.
- Snap_Miss clears only on the next accepted Snap; if both occur in one cycle, clear wins.
- Snap in the same cycle as the final-byte handshake: accepted. New values latched, next state HDR, Busy stays 1, zero bubble between frames.
- Cnt0/Cnt1 changes after the capture edge never affect the frame in flight.

Optional Feature:
- Macro SNAP_CKSUM_EN.
- Defined: CKS state present; Tx_Last on the checksum byte; 18-byte frame.
- Undefined: CKS state and XOR accumulator removed; Tx_Last on the final C1 byte; 17-byte frame. All other timing unchanged.

Decomposition:
- Shared package count_pkg holds:
  - state enum (IDLE, HDR, C0, C1, CKS);
  - HDR_BYTE default;
  - CNT_BYTES = CNT_W/8;
  - frame-length constants for both macro settings.
- One sub-module is natural: snap_byte_mux, selecting byte[index] from a latched CNT_W word (combinational, reused for C0 and C1).
- FSM, index counter and checksum register stay in the top.

Test Plan:
- Basic frame: Cnt0=64'h0102030405060708, Cnt1=0, Snap pulse, Tx_Ready=1. Expect A5,08,07,06,05,04,03,02,01, eight 00, then 08 with Tx_Last. Busy high for exactly 18 cycles.
- Backpressure: same frame with Tx_Ready toggled 1-0-0-1 per cycle. Byte sequence is identical; Tx_Data/Tx_Last are stable during every Ready=0 cycle.
- Snapshot isolation: Cnt0 changes every cycle after Snap. Frame carries only the capture-edge value.
- Dropped request: Snap mid-frame, then Snap=1 in the cycle after Tx_Last handshake. Snap_Miss=1 persists; the next frame starts; Snap_Miss clears.
- Back-to-back: Snap coincident with the Tx_Last handshake. Header of frame 2 is valid the next cycle, Busy never drops, both frames correct.
- Async reset mid-frame: Reset low at byte 5, asynchronously to Clk. All outputs 0 immediately. After release, a new Snap produces a complete correct frame.
- With SNAP_CKSUM_EN undefined, repeat the basic frame: 17 bytes, Tx_Last on the final 00 byte.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types and constants for the counter snapshot transmitter.
package count_pkg;
  typedef enum logic [2:0] {IDLE, HDR, C0, C1, CKS} state_e;

  localparam logic [7:0] HDR_BYTE_DEF    = 8'hA5;
  localparam int         CNT_W_DEF       = 64;
  localparam int         CNT_BYTES       = CNT_W_DEF / 8;
  localparam int         FRAME_LEN_CKS   = 2 + 2 * CNT_BYTES;
  localparam int         FRAME_LEN_NOCKS = 1 + 2 * CNT_BYTES;

  // Byte-index width; never zero so a single-byte counter still has an index.
  function automatic int idx_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction
endpackage

// File: rtl/snap_byte_mux.sv
// Combinational byte selector: byte[i_idx] of a latched counter word, LSB byte = 0.
module snap_byte_mux #(
  parameter int CNT_W = 64,
  parameter int IDX_W = 3
) (
  input  logic [CNT_W-1:0] i_word,
  input  logic [IDX_W-1:0] i_idx,
  output logic [7:0]       o_byte
);
  assign o_byte = i_word[i_idx*8 +: 8];
endmodule

// File: rtl/count_snapshot_tx.sv
// Atomically captures two counters and streams them as a byte-framed packet.
// Optional checksum byte enabled by defining SNAP_CKSUM_EN.
module count_snapshot_tx
  import count_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_DEF,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [CNT_W-1:0] Cnt0,
  input  logic [CNT_W-1:0] Cnt1,
  input  logic             Snap,
  output logic             Busy,
  output logic             Snap_Miss,
  output logic [7:0]       Tx_Data,
  output logic             Tx_Valid,
  input  logic             Tx_Ready,
  output logic             Tx_Last
);
  localparam int             NB       = CNT_W / 8;
  localparam int             IW       = idx_w(NB);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NB - 1);

  state_e           r_state, w_next;
  logic [CNT_W-1:0] r_snap0, r_snap1;
  logic [IW-1:0]    r_idx;
  logic             r_busy, r_miss;
  logic [CNT_W-1:0] w_word;
  logic [7:0]       w_byte, w_data;
  logic             w_hs, w_pay, w_idx_end, w_lastf, w_final, w_accept;
`ifdef SNAP_CKSUM_EN
  logic [7:0]       r_cks;
`endif

  assign w_word = (r_state == C1) ? r_snap1 : r_snap0;

  snap_byte_mux #(.CNT_W(CNT_W), .IDX_W(IW)) u_mux (
    .i_word (w_word),
    .i_idx  (r_idx),
    .o_byte (w_byte)
  );

  assign w_hs      = r_busy && Tx_Ready;
  assign w_pay     = (r_state == C0) || (r_state == C1);
  assign w_idx_end = (r_idx == LAST_IDX);
  assign w_final   = w_hs && w_lastf;
  // A Snap on the final-byte handshake starts the next frame with no bubble.
  assign w_accept  = Snap && ((r_state == IDLE) || w_final);

  always_comb begin
    w_next  = r_state;
    w_data  = 8'h00;
    w_lastf = 1'b0;
    case (r_state)
      IDLE: if (Snap) w_next = HDR;
      HDR: begin
        w_data = HDR_BYTE;
        if (w_hs) w_next = C0;
      end
      C0: begin
        w_data = w_byte;
        if (w_hs && w_idx_end) w_next = C1;
      end
      C1: begin
        w_data = w_byte;
`ifdef SNAP_CKSUM_EN
        if (w_hs && w_idx_end) w_next = CKS;
`else
        w_lastf = w_idx_end;
        if (w_hs && w_idx_end) w_next = Snap ? HDR : IDLE;
`endif
      end
`ifdef SNAP_CKSUM_EN
      CKS: begin
        w_data  = r_cks;
        w_lastf = 1'b1;
        if (w_hs) w_next = Snap ? HDR : IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_miss  <= 1'b0;
      r_snap0 <= '0;
      r_snap1 <= '0;
      r_idx   <= '0;
`ifdef SNAP_CKSUM_EN
      r_cks   <= 8'h00;
`endif
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      if (w_accept) begin
        r_snap0 <= Cnt0;
        r_snap1 <= Cnt1;
        r_idx   <= '0;
        r_miss  <= 1'b0;
`ifdef SNAP_CKSUM_EN
        r_cks   <= 8'h00;
`endif
      end else begin
        if (Snap && r_busy) r_miss <= 1'b1;
        if (w_hs && w_pay) begin
          r_idx <= w_idx_end ? '0 : r_idx + 1'b1;
`ifdef SNAP_CKSUM_EN
          r_cks <= r_cks ^ w_byte;
`endif
        end
      end
    end
  end

  assign Busy      = r_busy;
  assign Tx_Valid  = r_busy;
  assign Tx_Data   = w_data;
  assign Tx_Last   = w_lastf;
  assign Snap_Miss = r_miss;
endmodule

// File: tb/tb_count_snapshot_tx.sv
// Directed bench for count_snapshot_tx; frame length follows SNAP_CKSUM_EN.
module tb_count_snapshot_tx;
`ifdef SNAP_CKSUM_EN
  localparam int FLEN = 18;
`else
  localparam int FLEN = 17;
`endif

  logic        Clk = 1'b0, Reset = 1'b0, Snap = 1'b0, Tx_Ready = 1'b0;
  logic [63:0] Cnt0 = '0, Cnt1 = '0;
  logic        Busy, Snap_Miss, Tx_Valid, Tx_Last;
  logic [7:0]  Tx_Data;
  int          vecs = 0, errs = 0;

  count_snapshot_tx dut (
    .Clk(Clk), .Reset(Reset), .Cnt0(Cnt0), .Cnt1(Cnt1), .Snap(Snap),
    .Busy(Busy), .Snap_Miss(Snap_Miss), .Tx_Data(Tx_Data),
    .Tx_Valid(Tx_Valid), .Tx_Ready(Tx_Ready), .Tx_Last(Tx_Last)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; pulses Snap across one edge and checks 1-cycle latency.
  task automatic start(input logic [63:0] c0, input logic [63:0] c1);
    Cnt0 = c0; Cnt1 = c1; Snap = 1'b1; Tx_Ready = 1'b1;
    @(posedge Clk); #1;
    Snap = 1'b0;
    chk("start_busy", Busy, 1);
    chk("start_valid", Tx_Valid, 1);
  endtask

  // Receives one frame; rmode 1 = Ready 1-0-0-1; snap_at pulses Snap while byte k is offered.
  task automatic recv(input logic [63:0] e0, input logic [63:0] e1, input int rmode,
                      input int snap_at, input logic [63:0] n0, input logic [63:0] n1,
                      input bit churn, output int ncyc);
    logic [7:0] ex [0:17];
    logic [7:0] cks, pd;
    bit pr, sdone;
    int k, cyc;
    cks = 8'h00;
    ex[0] = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      ex[1+i] = e0[8*i +: 8];
      ex[9+i] = e1[8*i +: 8];
      cks = cks ^ e0[8*i +: 8] ^ e1[8*i +: 8];
    end
    ex[17] = cks;
    k = 0; cyc = 0; pr = 1'b1; sdone = 1'b0; pd = 8'h00;
    while (k < FLEN && cyc < 300) begin
      chk("valid", Tx_Valid, 1);
      chk("data", Tx_Data, ex[k]);
      chk("last", Tx_Last, (k == FLEN-1));
      if (!pr) chk("hold_data", Tx_Data, pd);
      Tx_Ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (k == snap_at && !sdone) begin
        Snap = 1'b1; Cnt0 = n0; Cnt1 = n1; sdone = 1'b1;
      end
      if (churn) Cnt0 = {$urandom, $urandom};
      pd = Tx_Data; pr = Tx_Ready;
      if (Tx_Ready) k++;
      @(posedge Clk); #1;
      Snap = 1'b0;
      cyc++;
    end
    if (k < FLEN) chk("frame_timeout", k, FLEN);
    ncyc = cyc;
  endtask

  initial begin
    int n;
    #2;
    chk("rst_busy", Busy, 0);
    chk("rst_valid", Tx_Valid, 0);
    chk("rst_last", Tx_Last, 0);
    chk("rst_data", Tx_Data, 0);
    chk("rst_miss", Snap_Miss, 0);
    #10 Reset = 1'b1;
    @(posedge Clk); #1;

    // Basic frame, Busy exactly FLEN cycles
    start(64'h0102030405060708, 64'h0);
    recv(64'h0102030405060708, 64'h0, 0, -1, 0, 0, 0, n);
    chk("basic_len", n, FLEN);
    chk("basic_busy_end", Busy, 0);
    chk("basic_valid_end", Tx_Valid, 0);

    // Backpressure
    start(64'h0102030405060708, 64'h0);
    recv(64'h0102030405060708, 64'h0, 1, -1, 0, 0, 0, n);
    chk("bp_busy_end", Busy, 0);

    // Snapshot isolation: Cnt0 churns after capture
    start(64'h1122334455667788, 64'hCAFEF00DDEADBEEF);
    recv(64'h1122334455667788, 64'hCAFEF00DDEADBEEF, 0, -1, 0, 0, 1, n);

    // Dropped request mid-frame, then accepted Snap clears the sticky flag
    start(64'h00000000000000FF, 64'h8000000000000001);
    recv(64'h00000000000000FF, 64'h8000000000000001, 0, 3,
         64'hDEADDEADDEADDEAD, 64'hBEEFBEEFBEEFBEEF, 0, n);
    chk("miss_set", Snap_Miss, 1);
    chk("miss_idle", Busy, 0);
    start(64'h0F0E0D0C0B0A0908, 64'h0706050403020100);
    chk("miss_clear", Snap_Miss, 0);
    recv(64'h0F0E0D0C0B0A0908, 64'h0706050403020100, 0, -1, 0, 0, 0, n);

    // Back-to-back: Snap on the final-byte handshake
    start(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555);
    recv(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 0, FLEN-1,
         64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 0, n);
    chk("b2b_busy", Busy, 1);
    chk("b2b_miss", Snap_Miss, 0);
    recv(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 0, -1, 0, 0, 0, n);
    chk("b2b_busy_end", Busy, 0);

    // Async reset mid-frame, between clock edges
    start(64'h1111111111111111, 64'h2222222222222222);
    repeat (6) @(posedge Clk);
    #3 Reset = 1'b0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_valid", Tx_Valid, 0);
    chk("arst_last", Tx_Last, 0);
    chk("arst_data", Tx_Data, 0);
    chk("arst_miss", Snap_Miss, 0);
    @(posedge Clk); #3 Reset = 1'b1;
    @(posedge Clk); #1;
    chk("arst_idle", Busy, 0);
    start(64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
    recv(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0, -1, 0, 0, 0, n);
    chk("arst_len", n, FLEN);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
